// File: rtl/tape_ram_loader.sv
// tape_ram_loader: streams a byte download through a small FIFO into the
// single-port system RAM whenever the arbiter grants the port. It then reads
// every written location back and compares the readback sum with the
// checksum of the bytes that were written.
//
// Handshakes:
// - A download byte transfers on a rising edge where dl_valid & dl_ready.
// - A RAM access happens in a cycle where ram_req & ram_grant. ram_wren
//   marks that access as a write.
// - Read data returns on ram_q one cycle after the granted read cycle.
module tape_ram_loader #(
    parameter int address_width   = 16,
    parameter int data_width      = 8,
    parameter int fifo_depth_log2 = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     dl_start,
    input  logic [address_width-1:0] dl_base,
    input  logic                     dl_valid,
    input  logic [data_width-1:0]    dl_data,
    output logic                     dl_ready,
    input  logic                     dl_end,
    output logic                     ram_req,
    input  logic                     ram_grant,
    output logic                     ram_wren,
    output logic [address_width-1:0] ram_address,
    output logic [data_width-1:0]    ram_data,
    input  logic [data_width-1:0]    ram_q,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [data_width-1:0]    checksum,
    output logic [address_width:0]   count,
    output logic [1:0]               fsm_state
);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    localparam int depth = 1 << fifo_depth_log2;

    state_t                     state, state_next;
    logic [address_width-1:0]   base;
    logic [data_width-1:0]      fifo_mem [depth];
    logic [fifo_depth_log2:0]   wr_ptr, rd_ptr, level;
    logic                       fifo_empty, fifo_full;
    logic [data_width-1:0]      fifo_head;
    logic                       end_flag;
    logic [address_width:0]     index;
    logic                       pend;
    logic [data_width-1:0]      rsum;
    logic                       count_full;
    logic                       push, pop, drop, rd_grant, verify_finish;

    // The pointers carry one extra bit, so the top bit of the fill level is
    // set exactly when the FIFO is full.
    assign level      = wr_ptr - rd_ptr;
    assign fifo_empty = (level == '0);
    assign fifo_full  = level[fifo_depth_log2];
    assign fifo_head  = fifo_mem[rd_ptr[fifo_depth_log2-1:0]];
    assign count_full = count[address_width];

    assign busy      = (state == LOAD) || (state == VERIFY);
    assign done      = (state == DONE);
    assign fsm_state = state;

    // Next state, RAM port drive and FIFO strobes; dl_start overrides everything.
    always_comb begin
        state_next    = state;
        dl_ready      = 1'b0;
        ram_req       = 1'b0;
        ram_wren      = 1'b0;
        ram_address   = '0;
        ram_data      = '0;
        push          = 1'b0;
        pop           = 1'b0;
        drop          = 1'b0;
        rd_grant      = 1'b0;
        verify_finish = 1'b0;
        case (state)
            LOAD: begin
                dl_ready = !fifo_full;
                push     = dl_valid && !fifo_full;
                if (!fifo_empty && !count_full) begin
                    ram_req     = 1'b1;
                    ram_address = base + count[address_width-1:0];
                    ram_data    = fifo_head;
                    if (ram_grant) begin
                        ram_wren = 1'b1;
                        pop      = 1'b1;
                    end
                end
                // Past the top of RAM, bytes keep draining so the source never stalls.
                if (!fifo_empty && count_full) begin
                    drop = 1'b1;
                    pop  = 1'b1;
                end
                if ((end_flag || dl_end) && fifo_empty && !push) begin
                    state_next = (count == '0) ? DONE : VERIFY;
                end
            end
            VERIFY: begin
                if (index < count) begin
                    ram_req     = 1'b1;
                    ram_address = base + index[address_width-1:0];
                    rd_grant    = ram_grant;
                end
                if ((index == count) && !pend) begin
                    verify_finish = 1'b1;
                    state_next    = DONE;
                end
            end
            default: begin
            end
        endcase
        if (dl_start) begin
            state_next = LOAD;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FIFO storage has no reset: an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (push && !dl_start) begin
            fifo_mem[wr_ptr[fifo_depth_log2-1:0]] <= dl_data;
        end
    end

    // Counters, checksums, FIFO pointers and error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            checksum <= '0;
            rsum     <= '0;
            error    <= 1'b0;
            end_flag <= 1'b0;
            index    <= '0;
            pend     <= 1'b0;
        end else if (dl_start) begin
            base     <= dl_base;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            checksum <= '0;
            rsum     <= '0;
            error    <= 1'b0;
            end_flag <= 1'b0;
            index    <= '0;
            pend     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ram_wren) begin
                count    <= count + 1'b1;
                checksum <= checksum + ram_data;
            end
            if ((state == LOAD) && dl_end) begin
                end_flag <= 1'b1;
            end
            if (rd_grant) begin
                index <= index + 1'b1;
            end
            pend <= rd_grant;
            if (pend) begin
                rsum <= rsum + ram_q;
            end
            error <= error | drop | (verify_finish & (rsum != checksum));
        end
    end

endmodule

// File: doc/tape_ram_loader.md
# tape_ram_loader

Streams a byte download (tape image or ROM/RAM snapshot from the HPS download channel) into the system `spram` through its single port. It buffers incoming bytes in a small FIFO, writes them on cycles where the RAM arbiter grants the port, then reads every written location back and compares checksums. It sits directly upstream of the RAM, sharing its port with the CPU through `ram_grant`.

## Interface
- `address_width`, 16: RAM address width; must match the downstream RAM.
- `data_width`, 8: byte width; also the width of the checksum.
- `fifo_depth_log2`, 2: FIFO holds 2^n entries (default 4).

- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; clears all state.
- `dl_start`  in  1  one-cycle pulse; latches `dl_base`, clears counters, enters LOAD.
- `dl_base`  in  address_width  first RAM address of the download.
- `dl_valid`  in  1  `dl_data` holds a byte.
- `dl_data`  in  data_width  download byte.
- `dl_ready`  out  1  byte accepted on an edge where `dl_valid & dl_ready`.
- `dl_end`  in  1  one-cycle pulse: no more bytes. May coincide with the last accepted byte.
- `ram_req`  out  1  loader wants the RAM port.
- `ram_grant`  in  1  arbiter gives the port this cycle (combinational from arbiter).
- `ram_wren`  out  data 1  RAM write enable.
- `ram_address`  out  address_width  RAM address.
- `ram_data`  out  data_width  RAM write data.
- `ram_q`  in  data_width  RAM registered read data; one-cycle latency.
- `busy`  out  1  high in LOAD and VERIFY.
- `done`  out  1  high in DONE until the next `dl_start`.
- `error`  out  1  overflow or checksum mismatch; valid when `done`.
- `checksum`  out  data_width  sum of written bytes, modulo 2^data_width.
- `count`  out  address_width+1  number of bytes written.

## Operation
- States: IDLE, LOAD, VERIFY, DONE. After reset the block is in IDLE, and all outputs are 0.
- `dl_start` in any state goes to LOAD and:
  - clears the FIFO, `count`, `checksum`, the readback sum, `error` and the end flag;
  - latches the base address;
  - aborts any operation in progress.
- LOAD:
  - `dl_ready` = (FIFO not full), combinational.
  - Each accepted byte is pushed into the FIFO.
  - `ram_req` = (FIFO not empty).
  - On a cycle with `ram_req & ram_grant`:
    - `ram_wren` = 1;
    - `ram_address` = base + `count`, truncated to address_width (wraps past the top of RAM);
    - `ram_data` = FIFO head.
    - At the edge, the FIFO pops, `count` increments and `checksum` += byte.
  - `ram_wren` is 0 on every other cycle and in every other state.
- Overflow: once `count` = 2^address_width, further bytes are still accepted, so the source never stalls. They are dropped without a RAM write, and `error` is set.
- `dl_end` sets the end flag. When the end flag is set and the FIFO is empty, LOAD goes to VERIFY, or to DONE if `count` = 0.
- VERIFY:
  - `ram_req` = 1 while read index < `count`.
  - `ram_address` = base + index.
  - On a granted cycle the index increments.
  - In the cycle after each granted read, `ram_q` is added to the readback sum.
  - After the last readback accumulates, the block goes to DONE, and `error` |= (readback sum ≠ `checksum`).
  - On overflow only the first 2^address_width locations are verified.
- DONE:
  - `done` = 1.
  - `busy` = 0.
  - `count`, `checksum` and `error` hold.
- `dl_valid` outside LOAD is ignored (`dl_ready` = 0).
- If `dl_end` arrives outside LOAD, it is ignored.

## Timing
- FIFO is registered: a byte accepted at edge k can be written at the earliest in cycle k+1, when granted.
- With `ram_grant` held at 1, throughput is one byte per clock and the FIFO never fills.
- `ram_req`, `ram_wren`, `ram_address` and `ram_data` are valid in the cycle they are used. `ram_wren` depends combinationally on `ram_grant`.
- Readback: the address is presented in granted cycle j, and `ram_q` is sampled in cycle j+1 whether or not the port is granted in j+1.
- DONE is entered on the edge after the cycle in which the last readback is accumulated.
- With constant grant, N bytes take N+2 cycles from entering VERIFY to `done`.
- Reset asserted mid-operation clears everything immediately. Bytes already written to RAM stay there. `dl_ready` is 0 until the next `dl_start`.

## Test plan
- Basic load:
  - Stimulus: `dl_start`, base 0x0500, bytes 0x11, 0x22, 0x33, `dl_end` with the last byte, grant = 1.
  - Required: RAM 0x0500..0x0502 written in order; `count` = 3; `checksum` = 0x66; `done` = 1; `error` = 0.
- Grant starvation:
  - Stimulus: `ram_grant` = 0 while 6 bytes are offered.
  - Required: `dl_ready` drops after 4 accepts. When grant returns, all 6 bytes are written, with no loss or duplication.
- Wrap-around:
  - Stimulus: base 0xFFFE, 4 bytes.
  - Required: writes land at 0xFFFE, 0xFFFF, 0x0000, 0x0001; verify passes.
- Corruption:
  - Stimulus: force a different `ram_q` during one VERIFY readback.
  - Required: `done` = 1, `error` = 1.
- Empty and abort:
  - Stimulus: `dl_end` with 0 bytes.
  - Required: DONE next cycle, with `count` = 0, `checksum` = 0, `error` = 0.
  - Stimulus: a new `dl_start` mid-LOAD.
  - Required: counters cleared and a fresh load at the new base.
- Reset:
  - Stimulus: `reset_n` pulsed low mid-VERIFY.
  - Required: all outputs 0 asynchronously; IDLE after release.
